// File: rtl/cpu_sequencer_if.sv
// Instruction-memory, data-memory and datapath-control bundle between the
// sequencer (master) and the memories / ALU / register file (slave).
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic                imem_ack;
  logic                alu_en;
  logic [3:0]          opcode;
  logic [3:0]          rd;
  logic [3:0]          rs1;
  logic [3:0]          rs2;
  logic                reg_write;
  logic                dmem_req;
  logic                dmem_we;
  logic [PC_WIDTH-1:0] dmem_addr;
  logic                dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output alu_en, opcode, rd, rs1, rs2, reg_write,
    output dmem_req, dmem_we, dmem_addr,
    input  dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  alu_en, opcode, rd, rs1, rs2, reg_write,
    input  dmem_req, dmem_we, dmem_addr,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the tiny CPU core: owns pc,
// ir and the retired-instruction counter and strobes ALU, dmem and regfile.
module cpu_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 zero_flag,
  cpu_sequencer_if.master      bus,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] OP_BRZ   = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t               r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [15:0]          r_ir;
  logic [CNT_WIDTH-1:0] r_instret;
  logic                 r_imem_req;
  logic                 r_alu_en;
  logic                 r_reg_write;
  logic                 r_dmem_req;
  logic                 r_dmem_we;
  logic                 r_busy;
  logic                 r_halted;

  state_t               w_state_nxt;
  logic [PC_WIDTH-1:0]  w_pc_nxt;
  logic [15:0]          w_ir_nxt;
  logic                 w_retire;
  logic [3:0]           w_op;
  logic [3:0]           w_op_nxt;

  function automatic logic f_is_alu(input logic [3:0] op);
    return (op <= 4'h3);
  endfunction

  assign w_op     = r_ir[15:12];
  assign w_op_nxt = w_ir_nxt[15:12];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_ir_nxt    = bus.imem_rdata;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (f_is_alu(w_op)) begin
          w_state_nxt = S_WB;
        end else if (w_op == OP_BRZ) begin
          // Taken branch replaces the pc+1 already applied during fetch.
          if (zero_flag) w_pc_nxt = PC_WIDTH'(r_ir[7:0]);
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_op == OP_LOAD || w_op == OP_STORE) begin
          w_state_nxt = S_MEM;
        end else if (w_op == OP_HALT) begin
          w_retire    = 1'b1;
          w_state_nxt = S_HALTED;
        end else begin
          w_retire    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (w_op == OP_STORE) begin
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is aligned with
  // the state it belongs to while still coming straight out of a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_instret   <= '0;
      r_imem_req  <= 1'b0;
      r_alu_en    <= 1'b0;
      r_reg_write <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_instret   <= r_instret + CNT_WIDTH'(w_retire);
      r_imem_req  <= (w_state_nxt == S_FETCH);
      r_alu_en    <= (w_state_nxt == S_EXEC) && f_is_alu(w_op_nxt);
      r_reg_write <= (w_state_nxt == S_WB);
      r_dmem_req  <= (w_state_nxt == S_MEM);
      r_dmem_we   <= (w_state_nxt == S_MEM) && (w_op_nxt == OP_STORE);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALTED);
      r_halted    <= (w_state_nxt == S_HALTED);
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.alu_en    = r_alu_en;
  assign bus.opcode    = r_ir[15:12];
  assign bus.rd        = r_ir[11:8];
  assign bus.rs1       = r_ir[7:4];
  assign bus.rs2       = r_ir[3:0];
  assign bus.reg_write = r_reg_write;
  assign bus.dmem_req  = r_dmem_req;
  assign bus.dmem_we   = r_dmem_we;
  assign bus.dmem_addr = PC_WIDTH'(r_ir[7:0]);

  assign pc      = r_pc;
  assign state   = r_state;
  assign busy    = r_busy;
  assign halted  = r_halted;
  assign instret = r_instret;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model predicts the
// ordered stream of fetches, strobes and memory accesses the DUT must produce.
module tb_cpu_sequencer;

  localparam int EV_FETCH = 0;
  localparam int EV_ALU   = 1;
  localparam int EV_REGWR = 2;
  localparam int EV_DMEM  = 3;
  localparam int EV_HALT  = 4;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          gap;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        zero_flag = 1'b0;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        busy;
  logic        halted;
  logic [15:0] instret;

  cpu_sequencer_if #(.PC_WIDTH(8)) bus();

  cpu_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .zero_flag(zero_flag), .bus(bus),
    .pc(pc), .state(state), .busy(busy), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  ev_t         expq[$];
  logic [15:0] g_prog[$];
  logic        g_zf[$];
  int          g_fidx = 0;
  int          g_maxw = 0;
  logic        slave_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level interpretation of the program stream.
  task automatic build_model();
    logic [7:0]  m_pc  = 8'h00;
    logic [15:0] m_ret = 16'h0;
    int          gap   = 0;
    logic [15:0] ins;
    logic [3:0]  op;
    for (int i = 0; i < g_prog.size(); i++) begin
      ins = g_prog[i];
      op  = ins[15:12];
      expq.push_back('{EV_FETCH, {24'h0, m_pc}, {16'h0, m_ret}, gap});
      m_pc = m_pc + 8'd1;
      m_ret = m_ret + 16'd1;
      if (op <= 4'h3) begin
        expq.push_back('{EV_ALU, {16'h0, ins}, 32'h0, -1});
        expq.push_back('{EV_REGWR, {28'h0, ins[11:8]}, 32'h0, -1});
        gap = 3;
      end else if (op == 4'h4) begin
        if (g_zf[i]) m_pc = ins[7:0];
        gap = 2;
      end else if (op == 4'h5) begin
        expq.push_back('{EV_DMEM, {24'h0, ins[7:0]}, 32'h0, -1});
        expq.push_back('{EV_REGWR, {28'h0, ins[11:8]}, 32'h0, -1});
        gap = 3;
      end else if (op == 4'h6) begin
        expq.push_back('{EV_DMEM, {24'h0, ins[7:0]}, 32'h1, -1});
        gap = 2;
      end else if (op == 4'hF) begin
        expq.push_back('{EV_HALT, {16'h0, m_ret}, 32'h0, 2});
        break;
      end else begin
        gap = 2;
      end
    end
  endtask

  // Memory / datapath responder with random wait states.
  initial begin
    int iw = 0;
    int dw = 0;
    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (!rst && bus.imem_req) begin
          if (iw == 0) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = (g_fidx < g_prog.size()) ? g_prog[g_fidx] : 16'hF000;
            zero_flag      = (g_fidx < g_zf.size()) ? g_zf[g_fidx] : 1'b0;
            g_fidx++;
            iw = $urandom_range(0, g_maxw);
          end else iw--;
        end
        if (!rst && bus.dmem_req) begin
          if (dw == 0) begin
            bus.dmem_ack = 1'b1;
            dw = $urandom_range(0, g_maxw);
          end else dw--;
        end
      end
    end
  end

  task automatic take(input string nm, input int kind, input logic [31:0] a,
                      input logic [31:0] b, input int gap);
    ev_t e;
    if (expq.size() == 0) begin
      chk({nm, "_unexpected"}, 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = expq.pop_front();
    chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
    chk({nm, "_a"}, a, e.a);
    chk({nm, "_b"}, b, e.b);
    if (e.gap >= 0) chk({nm, "_latency"}, 32'(gap), 32'(e.gap));
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  initial begin
    int   gap    = 0;
    logic prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap    = 0;
        prev_h = 1'b0;
      end else begin
        if ((32'(bus.alu_en) + 32'(bus.reg_write) + 32'(bus.dmem_req)) != 0)
          chk("strobe_exclusive",
              32'(bus.alu_en) + 32'(bus.reg_write) + 32'(bus.dmem_req), 32'd1);
        if (bus.imem_req && bus.imem_ack) begin
          take("fetch", EV_FETCH, {24'h0, bus.imem_addr}, {16'h0, instret}, gap);
          gap = 0;
        end
        if (bus.alu_en)
          take("alu", EV_ALU, {16'h0, bus.opcode, bus.rd, bus.rs1, bus.rs2}, 32'h0, 0);
        if (bus.reg_write)
          take("regwr", EV_REGWR, {28'h0, bus.rd}, 32'h0, 0);
        if (bus.dmem_req && bus.dmem_ack)
          take("dmem", EV_DMEM, {24'h0, bus.dmem_addr}, {31'h0, bus.dmem_we}, 0);
        if (halted && !prev_h) begin
          take("halt", EV_HALT, {16'h0, instret}, {31'h0, busy}, gap);
          gap = 0;
        end
        if (busy && !bus.imem_req && !bus.dmem_req) gap++;
        prev_h = halted;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_flags", {28'h0, busy, halted, bus.imem_req, bus.dmem_req}, 32'h0);
    chk("rst_strobes", {29'h0, bus.alu_en, bus.reg_write, bus.dmem_we}, 32'h0);
    chk("rst_fields", {16'h0, bus.opcode, bus.rd, bus.rs1, bus.rs2}, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic run_prog(input string nm);
    int c;
    do_reset();
    expq.delete();
    build_model();
    g_fidx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 4000 && !halted; c++) tick();
    chk({nm, "_halt_reached"}, {31'h0, halted}, 32'h1);
    tick();
    tick();
    chk({nm, "_events_left"}, 32'(expq.size()), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk({nm, "_stay_halted"}, {28'h0, halted, busy, bus.imem_req, 1'b0}, 32'h8);
    chk({nm, "_halt_state"}, 32'(state), 32'd6);
  endtask

  task automatic set_prog(input logic [15:0] ins, input logic zf);
    g_prog.push_back(ins);
    g_zf.push_back(zf);
  endtask

  initial begin
    // ADD then HALT, zero wait.
    g_maxw = 0;
    g_prog.delete(); g_zf.delete();
    set_prog(16'h0123, 1'b0); set_prog(16'hF000, 1'b0);
    run_prog("add");
    chk("add_pc", 32'(pc), 32'd2);

    // LOAD with waits.
    g_maxw = 3;
    g_prog.delete(); g_zf.delete();
    set_prog(16'h5A40, 1'b0); set_prog(16'hF000, 1'b0);
    run_prog("load");

    // BRZ at pc=5 taken to 0x37, branch back, then not taken.
    g_maxw = 0;
    g_prog.delete(); g_zf.delete();
    for (int i = 0; i < 5; i++) set_prog(16'h7000, 1'b0);
    set_prog(16'h4037, 1'b1); set_prog(16'h4005, 1'b1);
    set_prog(16'h4037, 1'b0); set_prog(16'hF000, 1'b0);
    run_prog("brz");
    chk("brz_pc", 32'(pc), 32'd7);

    // STORE then HALT.
    g_maxw = 1;
    g_prog.delete(); g_zf.delete();
    set_prog(16'h6012, 1'b0); set_prog(16'hF000, 1'b0);
    run_prog("store");
    chk("store_instret", 32'(instret), 32'd2);

    // pc wrap: branch to 0xFF, NOP there, next fetch at 0x00.
    g_maxw = 0;
    g_prog.delete(); g_zf.delete();
    set_prog(16'h40FF, 1'b1); set_prog(16'h7000, 1'b0); set_prog(16'hF000, 1'b0);
    run_prog("wrap");
    chk("wrap_pc", 32'(pc), 32'd1);

    // Random programs.
    for (int r = 0; r < 6; r++) begin
      g_maxw = (r % 2 == 0) ? 0 : 3;
      g_prog.delete(); g_zf.delete();
      for (int i = 0; i < 40; i++)
        set_prog({4'($urandom_range(0, 14)), 12'($urandom)}, 1'($urandom));
      set_prog({4'hF, 12'($urandom)}, 1'b0);
      run_prog("rand");
    end

    // Reset mid-fetch with ack in the same cycle.
    do_reset();
    expq.delete();
    slave_en = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rstfetch_req", {31'h0, bus.imem_req}, 32'h1);
    bus.imem_rdata = 16'h1234;
    bus.imem_ack   = 1'b1;
    rst = 1'b1;
    tick();
    chk("rstfetch_state", 32'(state), 32'd0);
    chk("rstfetch_pc", 32'(pc), 32'd0);
    chk("rstfetch_ir", {16'h0, bus.opcode, bus.rd, bus.rs1, bus.rs2}, 32'h0);
    chk("rstfetch_req_low", {31'h0, bus.imem_req}, 32'h0);
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("rstfetch_events", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle instruction sequencer for the tiny CPU core. It fetches a 16-bit instruction over a req/ack instruction-memory handshake and decodes the 4-bit opcode. It then steps the ALU, data-memory and register-file write enables through a fixed state machine. It owns the PC, the instruction register and a retired-instruction counter, and sits between the instruction/data memories and the ALU/register-file datapath.

Parameters:
PC_WIDTH, 8, program counter / memory address width; must be >= 8.
CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  leave IDLE and begin fetching; sampled only in IDLE
imem_req  output  1  instruction fetch request
imem_addr  output  PC_WIDTH  fetch address (= pc)
imem_rdata  input  16  instruction word, valid with imem_ack
imem_ack  input  1  fetch complete
zero_flag  input  1  ALU zero flag, sampled in EXEC for BR
alu_en  output  1  ALU operation strobe
opcode  output  4  ir[15:12]
rd  output  4  ir[11:8], destination register
rs1  output  4  ir[7:4]
rs2  output  4  ir[3:0]
reg_write  output  1  register-file write strobe
dmem_req  output  1  data memory request
dmem_we  output  1  1 = store, 0 = load; valid with dmem_req
dmem_addr  output  PC_WIDTH  zero-extended ir[7:0]
dmem_ack  input  1  data access complete
pc  output  PC_WIDTH  current program counter
state  output  3  current FSM state
busy  output  1  state not IDLE and not HALTED
halted  output  1  state == HALTED
instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, pc=0, ir=0, instret=0. All strobes, busy and halted are 0. opcode/rd/rs1/rs2 read 0. rst overrides all other inputs, including mid-handshake.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6. Codes 7 and above go to IDLE.
- Output timing: all outputs are functions of registered state, ir and pc only. There is no combinational path from any input to any output.
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 BRZ, 0101 LOAD, 0110 STORE, 1111 HALT. All other codes are NOPs.
- IDLE: start=1 -> FETCH. Otherwise stay in IDLE.
- FETCH: imem_req=1, imem_addr=pc, held until imem_ack. On imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps modulo 2^PC_WIDTH), go to DECODE. Any number of wait cycles is allowed.
- DECODE: single cycle -> EXEC.
- EXEC, ALU ops: alu_en=1 for exactly one cycle -> WB.
- EXEC, BRZ: if zero_flag=1, pc<=zero-extended ir[7:0] (the branch overrides the pc+1 made in FETCH); otherwise pc is unchanged. Either way -> FETCH, and instret increments.
- EXEC, LOAD/STORE -> MEM.
- EXEC, HALT -> HALTED, and instret increments.
- EXEC, NOP -> FETCH, and instret increments.
- MEM: dmem_req=1, dmem_we=(opcode==STORE), held until dmem_ack. On ack: LOAD -> WB; STORE -> FETCH with instret increment.
- WB: reg_write=1 for exactly one cycle, instret increments -> FETCH.
- HALTED: halted=1, busy=0. start is ignored; the block stays here until rst.
- Acks arriving outside the matching request state are ignored.
- instret wraps to 0 on overflow.
- Zero-wait latency, measured in cycles from entering FETCH to re-entering FETCH: ALU=4, LOAD=5, STORE=4, BRZ=3, NOP=3.
- reg_write, alu_en and dmem_req are never asserted in the same cycle.

Test Plan:
- Reset, then start, with imem returning 0x0123 (ADD rd=1 rs1=2 rs2=3) and zero-wait ack -> states 1,2,3,5,1. alu_en high in cycle 3, reg_write high in cycle 4 with rd=1. pc=1, instret=1.
- LOAD 0x5A40 with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0 and dmem_addr=0x40. Then WB pulses reg_write with rd=0xA.
- BRZ 0x4037 at pc=5: zero_flag=1 -> next fetch at imem_addr=0x37. zero_flag=0 -> next fetch at 0x06. instret increments in both cases.
- STORE 0x6012 followed by HALT 0xF000 -> dmem_we=1 with dmem_addr=0x12, then halted=1 and busy=0. A later start pulse is ignored. instret=2.
- rst asserted during FETCH with imem_req high and imem_ack high in the same cycle -> next cycle state=IDLE, pc=0, ir unchanged from 0, imem_req=0.
- pc=0xFF fetches a NOP -> pc wraps to 0x00. Next imem_addr=0x00.
